gain_bal_ctrl: RTL and testbench

//  Producer side of the gain/balance interface: owns the gain[63:0] and bal[31:0] buses consumed by
//  the 8-channel gain/balance multiplier. Host writes per-channel target values into staging registers;
//  a commit applies them at frame boundaries (frame_val), ramping each value by STEP per frame to

---
 rtl/gain_bal_pkg.sv | 37 +++
 rtl/gain_ramp_step.sv | 44 ++++
 rtl/gain_bal_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_gain_bal_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_bal_pkg.sv
// -----------------------------------------------------------------------------
// gain_bal_pkg
//   Shared definitions for the gain/balance producer block.
//   - Default channel counts (NCH gain bytes, NBAL balance bytes).
//   - Host address map for the byte-wide staging write port.
//   - Controller FSM state encoding.
// -----------------------------------------------------------------------------
package gain_bal_pkg;

  // Every live/target/staging value is one signed two's complement byte.
  localparam int BYTE_W  = 8;

  // Default sizes. The balance bus carries one byte per stereo pair,
  // so the gain channel count is always twice the pair count.
  localparam int GB_NCH  = 8;
  localparam int GB_NBAL = 4;

  // Host address map (4-bit byte address).
  //   0..7   gain[ch]
  //   8..11  bal[pair]
  //   12..15 unmapped, writes are dropped
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_GAIN0 = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_BAL0  = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = 4'd11;

  // Controller states.
  //   ST_IDLE  : live == target, nothing scheduled
  //   ST_ARMED : commit accepted, waiting for the next frame strobe
  //   ST_RAMP  : stepping live toward target once per frame
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RAMP  = 2'd2
  } gb_state_e;

endpackage : gain_bal_pkg

// File: rtl/gain_ramp_step.sv
// -----------------------------------------------------------------------------
// gain_ramp_step
//   Combinational stepper for one signed byte. Produces the value the byte
//   should take on the next frame: it moves toward target by at most STEP and
//   lands exactly on target when the remaining distance is STEP or less.
//   Distance is evaluated in 9-bit signed arithmetic, so the full -128..127
//   range is reachable without overshoot or wrap (e.g. 8'h7E -> 8'h81 walks
//   down through zero instead of crossing 8'h7F/8'h80).
//
// Ports
//   live      in  8  current live byte (signed)
//   target    in  8  committed target byte (signed)
//   next      out 8  live value after one frame step
//   at_target out 1  next == target (byte has settled after this step)
// -----------------------------------------------------------------------------
module gain_ramp_step
  import gain_bal_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [BYTE_W-1:0] live,
  input  logic [BYTE_W-1:0] target,
  output logic [BYTE_W-1:0] next,
  output logic              at_target
);

  // STEP is at most 127, so both +STEP and -STEP fit in 9 signed bits.
  localparam logic signed [BYTE_W:0] STEP_S = (BYTE_W+1)'(STEP);
  localparam logic [BYTE_W-1:0]      STEP_B = BYTE_W'(STEP);

  logic signed [BYTE_W:0] diff;

  always_comb begin
    diff = $signed({target[BYTE_W-1], target}) - $signed({live[BYTE_W-1], live});
    next = target;
    if (diff > STEP_S) begin
      next = live + STEP_B;
    end else if (diff < -STEP_S) begin
      next = live - STEP_B;
    end
    at_target = (next == target);
  end

endmodule : gain_ramp_step

// File: rtl/gain_bal_ctrl.sv
// -----------------------------------------------------------------------------
// gain_bal_ctrl
//   Producer of the gain/balance buses feeding the 8-channel multiplier.
//   The host stages bytes through a one-byte-per-cycle write port; a commit
//   copies staging into target, and live values then ramp toward target by
//   at most STEP per frame so the multiplier never sees a large jump.
//
//   Internally all values share one array indexed 0..NCH+NBAL-1: gain
//   channels first, then balance pairs, matching the host address map.
//
// Ports
//   clk        in   1       clock
//   rst        in   1       asynchronous active-high reset
//   wr_en      in   1       host byte write strobe
//   wr_addr    in   4       0..7 gain[ch], 8..11 bal[pair], 12..15 ignored
//   wr_data    in   8       signed byte to stage
//   commit     in   1       staging -> target, start a ramp
//   frame_val  in   1       one-cycle frame strobe from the datapath
//   gain       out  8*NCH   live gain bytes (registered)
//   bal        out  8*NBAL  live balance bytes (registered)
//   busy       out  1       a commit is armed or a ramp is running
//   ramp_done  out  1       one-cycle pulse after the step that settles live
//
// Handshake note: there is no back-pressure. wr_en, commit and frame_val are
// single-cycle strobes sampled on the rising clock edge; each sampled strobe
// is acted on exactly once. commit while busy is remembered in a single
// pending flag, so any number of such commits collapse into one follow-up
// ramp that uses the staging contents at the moment the current ramp ends.
// -----------------------------------------------------------------------------
module gain_bal_ctrl
  import gain_bal_pkg::*;
#(
  parameter int                NCH      = GB_NCH,
  parameter int                NBAL     = GB_NBAL,
  parameter int                STEP     = 1,
  parameter logic [BYTE_W-1:0] GAIN_RST = 8'h40,
  parameter logic [BYTE_W-1:0] BAL_RST  = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BYTE_W-1:0]    wr_data,
  input  logic                 commit,
  input  logic                 frame_val,
  output logic [BYTE_W*NCH-1:0]  gain,
  output logic [BYTE_W*NBAL-1:0] bal,
  output logic                 busy,
  output logic                 ramp_done
);

  localparam int NV = NCH + NBAL;

  function automatic logic [BYTE_W-1:0] rst_byte(input int idx);
    return (idx < NCH) ? GAIN_RST : BAL_RST;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [BYTE_W-1:0] stg_q  [NV];
  logic [BYTE_W-1:0] tgt_q  [NV];
  logic [BYTE_W-1:0] live_q [NV];

  // Staging as it will look after this cycle's write. Commit loads target
  // from this view so a write coinciding with commit is included.
  logic [BYTE_W-1:0] stg_d  [NV];
  logic [BYTE_W-1:0] step_nxt [NV];
  logic [NV-1:0]     at_tgt;
  logic              all_at;
  logic              wr_ok;

  gb_state_e state_q, state_d;
  logic      pending_q, pending_d;
  logic      done_q, done_d;
  logic      load_target;
  logic      do_step;

  // ---------------------------------------------------------------------------
  // Staging write decode
  // ---------------------------------------------------------------------------
  assign wr_ok = wr_en && (wr_addr <= ADDR_LAST);

  always_comb begin
    for (int i = 0; i < NV; i++) begin
      stg_d[i] = stg_q[i];
    end
    for (int c = 0; c < NCH; c++) begin
      if (wr_ok && (wr_addr == ADDR_GAIN0 + ADDR_W'(c))) begin
        stg_d[c] = wr_data;
      end
    end
    for (int p = 0; p < NBAL; p++) begin
      if (wr_ok && (wr_addr == ADDR_BAL0 + ADDR_W'(p))) begin
        stg_d[NCH+p] = wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-byte steppers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NV; g++) begin : g_step
    gain_ramp_step #(
      .STEP (STEP)
    ) u_step (
      .live      (live_q[g]),
      .target    (tgt_q[g]),
      .next      (step_nxt[g]),
      .at_target (at_tgt[g])
    );
  end

  assign all_at = &at_tgt;

  // ---------------------------------------------------------------------------
  // Controller FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM: next state and datapath controls
  //   A frame strobe in the same cycle as the accepting commit is ignored
  //   because the IDLE branch never steps. In ARMED and RAMP every frame
  //   strobe steps; the step that settles all bytes ends the ramp. A commit
  //   arriving in that very cycle is treated as pending and consumed at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    load_target = 1'b0;
    do_step     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (commit) begin
          load_target = 1'b1;
          state_d     = ST_ARMED;
        end
      end

      ST_ARMED, ST_RAMP: begin
        if (commit) begin
          pending_d = 1'b1;
        end
        if (frame_val) begin
          do_step = 1'b1;
          state_d = ST_RAMP;
          if (all_at) begin
            done_d = 1'b1;
            if (pending_q || commit) begin
              load_target = 1'b1;
              pending_d   = 1'b0;
              state_d     = ST_ARMED;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Staging / target / live registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        stg_q[i]  <= rst_byte(i);
        tgt_q[i]  <= rst_byte(i);
        live_q[i] <= rst_byte(i);
      end
    end else begin
      for (int i = 0; i < NV; i++) begin
        stg_q[i] <= stg_d[i];
        if (load_target) begin
          tgt_q[i] <= stg_d[i];
        end
        if (do_step) begin
          live_q[i] <= step_nxt[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_gain_out
    assign gain[c*BYTE_W +: BYTE_W] = live_q[c];
  end

  for (genvar p = 0; p < NBAL; p++) begin : g_bal_out
    assign bal[p*BYTE_W +: BYTE_W] = live_q[NCH+p];
  end

  assign busy      = (state_q != ST_IDLE);
  assign ramp_done = done_q;

endmodule : gain_bal_ctrl

// File: tb/tb_gain_bal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gain_bal_ctrl
//   Two instances (STEP=1 and STEP=4) share one stimulus stream. A reference
//   model of staging/target/live values, kept as plain integers, predicts
//   gain, bal, busy and ramp_done after every clock; directed sequences add
//   fixed expected values for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_gain_bal_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        commit = 1'b0;
  logic        frame_val = 1'b0;

  logic [63:0] g1, g4;
  logic [31:0] b1, b4;
  logic        bz1, bz4, rd1, rd4;

  always #5 clk = ~clk;

  gain_bal_ctrl #(.STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .frame_val(frame_val),
    .gain(g1), .bal(b1), .busy(bz1), .ramp_done(rd1)
  );

  gain_bal_ctrl #(.STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .frame_val(frame_val),
    .gain(g4), .bal(b4), .busy(bz4), .ramp_done(rd4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / check
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: values as signed integers, one set per STEP instance.
  //   in_flight : a commit has been accepted and its ramp is not finished
  //   pend      : another commit arrived while in flight
  // ---------------------------------------------------------------------------
  int  m_stg  [12];
  int  m_tgt  [2][12];
  int  m_live [2][12];
  bit  m_fl   [2];
  bit  m_pend [2];
  bit  m_done [2];
  int  m_step [2] = '{1, 4};

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_stg[i] = (i < 8) ? 64 : 0;
      for (int k = 0; k < 2; k++) begin
        m_tgt[k][i]  = m_stg[i];
        m_live[k][i] = m_stg[i];
      end
    end
    for (int k = 0; k < 2; k++) begin
      m_fl[k] = 0; m_pend[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_update(input bit we, input int a, input logic [7:0] d,
                              input bit c, input bit f);
    if (we && a < 12) m_stg[a] = int'($signed(d));
    for (int k = 0; k < 2; k++) begin
      bit nd = 0;
      if (!m_fl[k]) begin
        if (c) begin
          for (int i = 0; i < 12; i++) m_tgt[k][i] = m_stg[i];
          m_fl[k] = 1;
        end
      end else if (f) begin
        bit eq = 1;
        for (int i = 0; i < 12; i++) begin
          int dl = m_tgt[k][i] - m_live[k][i];
          if (dl > m_step[k])       m_live[k][i] += m_step[k];
          else if (dl < -m_step[k]) m_live[k][i] -= m_step[k];
          else                      m_live[k][i] = m_tgt[k][i];
          if (m_live[k][i] != m_tgt[k][i]) eq = 0;
        end
        if (eq) begin
          nd = 1;
          if (m_pend[k] || c) begin
            for (int i = 0; i < 12; i++) m_tgt[k][i] = m_stg[i];
            m_pend[k] = 0;
          end else begin
            m_fl[k] = 0;
          end
        end else if (c) begin
          m_pend[k] = 1;
        end
      end else if (c) begin
        m_pend[k] = 1;
      end
      m_done[k] = nd;
    end
  endtask

  function automatic logic [63:0] exp_gain(input int k);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(m_live[k][i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_bal(input int k);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(m_live[k][8+i]);
    return v;
  endfunction

  task automatic compare_all();
    check("s1_gain", g1, exp_gain(0));
    check("s1_bal",  {32'b0, b1}, {32'b0, exp_bal(0)});
    check("s1_busy", {63'b0, bz1}, {63'b0, m_fl[0]});
    check("s1_done", {63'b0, rd1}, {63'b0, m_done[0]});
    check("s4_gain", g4, exp_gain(1));
    check("s4_bal",  {32'b0, b4}, {32'b0, exp_bal(1)});
    check("s4_busy", {63'b0, bz4}, {63'b0, m_fl[1]});
    check("s4_done", {63'b0, rd4}, {63'b0, m_done[1]});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input bit we, input int a, input logic [7:0] d,
                      input bit c, input bit f);
    @(negedge clk);
    wr_en = we; wr_addr = 4'(a); wr_data = d; commit = c; frame_val = f;
    @(posedge clk);
    model_update(we, a, d, c, f);
    #1;
    wr_en = 0; commit = 0; frame_val = 0;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic frame();
    step(0, 0, 8'h00, 0, 1);
  endtask

  // Frames every other cycle until both instances settle, bounded.
  task automatic run_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!m_fl[0] && !m_fl[1]) break;
      step(0, 0, 8'h00, 0, (i % 2) == 0);
    end
    check("idle_bound", {63'b0, bz1 | bz4}, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gain", g1, 64'h4040404040404040);
    check("rst_bal",  {32'b0, b1}, 64'd0);
    check("rst_busy", {63'b0, bz1}, 64'd0);
    check("rst_done", {63'b0, rd4}, 64'd0);
    @(negedge clk);
    rst = 0;
    idle();
    frame();  // frame strobe in IDLE does nothing

    // Basic ramp: gain[0] 40 -> 44.
    step(1, 0, 8'h44, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check("basic_busy", {63'b0, bz1}, 64'd1);
    for (int n = 1; n <= 4; n++) begin
      frame();
      check("basic_g0", {56'b0, g1[7:0]}, 64'(8'h40 + n));
      check("basic_g1", {56'b0, g1[15:8]}, 64'h40);
      idle();
    end
    check("basic_idle", {63'b0, bz1}, 64'd0);
    frame();
    check("basic_hold", {56'b0, g1[7:0]}, 64'h44);

    // Signed ramp on bal[0]: 00 -> 02, then 02 -> FD.
    step(1, 8, 8'h02, 1, 0);
    run_idle();
    step(1, 8, 8'hFD, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    frame();
    check("sgn_b0_1", {56'b0, b4[7:0]}, 64'hFE);
    frame();
    check("sgn_b0_2", {56'b0, b4[7:0]}, 64'hFD);
    check("sgn_done", {63'b0, rd4}, 64'd1);
    run_idle();

    // No wrap: gain[1] up to 7E, then down to 81 through zero.
    step(1, 1, 8'h7E, 1, 0);
    run_idle();
    step(1, 1, 8'h81, 1, 0);
    frame();
    check("wrap_s4", {56'b0, g4[15:8]}, 64'h7A);
    run_idle();
    check("wrap_end", {56'b0, g1[15:8]}, 64'h81);

    // Coincidence: write+commit+frame in one cycle.
    step(1, 3, 8'h50, 1, 1);
    check("coin_nostep", {56'b0, g1[31:24]}, 64'h40);
    frame();
    check("coin_step", {56'b0, g1[31:24]}, 64'h41);
    run_idle();
    check("coin_tgt", {56'b0, g4[31:24]}, 64'h50);

    // Pending: commits during a ramp collapse into one follow-up ramp.
    step(1, 2, 8'h48, 1, 0);
    frame(); frame();
    step(1, 2, 8'h38, 1, 0);
    frame();
    step(1, 4, 8'h30, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    run_idle();
    check("pend_g2", {56'b0, g1[23:16]}, 64'h38);
    check("pend_g4", {56'b0, g1[39:32]}, 64'h30);

    // Unmapped address then no-op commit: one frame, done, no change.
    step(1, 13, 8'h11, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    frame();
    check("noop_done", {63'b0, rd1}, 64'd1);
    check("noop_busy", {63'b0, bz4}, 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0);
    end

    // Async reset in the middle of the low phase.
    step(1, 0, 8'h90, 1, 0);
    frame();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_gain", g1, 64'h4040404040404040);
    check("arst_bal",  {32'b0, b4}, 64'd0);
    check("arst_busy", {63'b0, bz1 | bz4}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle();
    frame();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gain_bal_ctrl
